// File: rtl/ethernet_rx_word_assembler.sv
// ethernet_rx_word_assembler: per-channel header-delimited word assembly into a tagged FWFT output FIFO
module ethernet_rx_word_assembler #(
    parameter int WORD_BYTES = 4,
    parameter int NCHAN = 8,
    parameter logic [3:0] HDR_NIBBLE = 4'hF,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT = 255,
    localparam int CW = NCHAN > 1 ? $clog2(NCHAN) : 1,
    localparam int W = 8 * WORD_BYTES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    data,
    input  logic          data_good,
    input  logic [CW-1:0] channel,
    output logic [W-1:0]  data_out,
    output logic [CW-1:0] data_out_channel,
    output logic          data_out_valid,
    input  logic          data_out_ready,
    output logic [15:0]   drop_count,
    output logic [15:0]   timeout_count,
    output logic [15:0]   overflow_count
);
    localparam int IW = $clog2(WORD_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NCHAN-1:0]  busy;
    logic [IW-1:0]     idx [NCHAN];
    logic [TW-1:0]     timer [NCHAN];
    logic [W-1:0]      word [NCHAN];
    logic [W+CW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       count;
    logic [NCHAN-1:0]  hit, expire;
    logic              hdr, push, pop, full, drop, wr_en;
    logic [W+CW-1:0]   push_data;
    logic [15:0]       n_expire;
    logic [16:0]       tmo_sum;

    always_comb begin
        hdr = data[7:4] == HDR_NIBBLE;
        push = 1'b0;
        push_data = '0;
        drop = 1'b0;
        n_expire = '0;
        for (int c = 0; c < NCHAN; c++) begin
            hit[c] = data_good && 32'(channel) == c;
            // a byte arriving on the expiry cycle keeps the word alive
            expire[c] = busy[c] && !hit[c] && TIMEOUT > 0 && 32'(timer[c]) + 1 >= TIMEOUT;
            n_expire = n_expire + 16'(expire[c]);
            if (hit[c] && busy[c] && idx[c] == IW'(WORD_BYTES - 1)) begin
                push = 1'b1;
                push_data = {word[c][W-9:0], data, CW'(c)};
            end
            if (hit[c] && !busy[c] && !hdr)
                drop = 1'b1;
        end
        tmo_sum = {1'b0, timeout_count} + {1'b0, n_expire};
    end

    assign full = count == (AW+1)'(FIFO_DEPTH);
    assign data_out_valid = count != '0;
    assign pop = data_out_valid && data_out_ready;
    assign wr_en = push && (!full || pop);
    assign {data_out, data_out_channel} = data_out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk)
        if (wr_en)
            mem[wr_ptr] <= push_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            drop_count <= '0;
            timeout_count <= '0;
            overflow_count <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                idx[c] <= '0;
                timer[c] <= '0;
                word[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (hit[c] && busy[c]) begin
                    word[c] <= {word[c][W-9:0], data};
                    timer[c] <= '0;
                    busy[c] <= idx[c] != IW'(WORD_BYTES - 1);
                    idx[c] <= idx[c] == IW'(WORD_BYTES - 1) ? '0 : idx[c] + 1'b1;
                end else if (hit[c] && hdr) begin
                    busy[c] <= 1'b1;
                    idx[c] <= IW'(1);
                    word[c] <= W'(data);
                    timer[c] <= '0;
                end else if (expire[c]) begin
                    busy[c] <= 1'b0;
                    idx[c] <= '0;
                    timer[c] <= '0;
                end else if (busy[c] && TIMEOUT > 0) begin
                    timer[c] <= timer[c] + 1'b1;
                end
            end
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 1'b1;
            timeout_count <= tmo_sum[16] ? 16'hFFFF : tmo_sum[15:0];
            if (push && !wr_en && overflow_count != 16'hFFFF)
                overflow_count <= overflow_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_ethernet_rx_word_assembler.sv
// tb_ethernet_rx_word_assembler: directed and random traffic checked through a scoreboard against a byte-queue model
module tb_ethernet_rx_word_assembler;
    localparam int NC = 6;
    localparam int TO = 4;
    localparam int DEPTH = 8;

    logic        clk = 0, rst = 1;
    logic [7:0]  data = 0;
    logic        data_good = 0;
    logic [2:0]  channel = 0;
    logic [31:0] data_out;
    logic [2:0]  data_out_channel;
    logic        data_out_valid;
    logic        data_out_ready = 0;
    logic [15:0] drop_count, timeout_count, overflow_count;

    always #5 clk = ~clk;

    ethernet_rx_word_assembler #(
        .WORD_BYTES(4), .NCHAN(NC), .HDR_NIBBLE(4'hF), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .data_good(data_good), .channel(channel),
        .data_out(data_out), .data_out_channel(data_out_channel), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .drop_count(drop_count), .timeout_count(timeout_count),
        .overflow_count(overflow_count)
    );

    int errors = 0, checks = 0;
    logic [7:0]  col [NC][$];
    int          gap [NC];
    int          occ, m_drop, m_tmo, m_ovf;
    logic [34:0] sb [$], log_q [$];
    logic [34:0] item, popped, phead;
    bit          mpop, mpush, pv, pr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: each channel collects bytes in a queue, a full queue of WORD_BYTES becomes a word
    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                col[c].delete();
                gap[c] = 0;
            end
            occ = 0; m_drop = 0; m_tmo = 0; m_ovf = 0;
            sb.delete();
        end else begin
            mpop = occ > 0 && data_out_ready;
            mpush = 0;
            for (int c = 0; c < NC; c++) begin
                if (data_good && channel == c) begin
                    if (col[c].size() == 0 && data[7:4] != 4'hF) begin
                        m_drop++;
                    end else begin
                        col[c].push_back(data);
                        gap[c] = 0;
                        if (col[c].size() == 4) begin
                            item = {col[c][0], col[c][1], col[c][2], col[c][3], 3'(c)};
                            mpush = 1;
                            col[c].delete();
                        end
                    end
                end else if (col[c].size() > 0) begin
                    gap[c]++;
                    if (gap[c] == TO) begin
                        col[c].delete();
                        gap[c] = 0;
                        m_tmo++;
                    end
                end
            end
            if (mpush) begin
                if (occ == DEPTH && !mpop) m_ovf++;
                else begin
                    sb.push_back(item);
                    occ++;
                end
            end
            if (mpop) occ--;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            pv = 0;
            pr = 0;
        end else begin
            chk("valid", 64'(data_out_valid), 64'(occ > 0));
            if (pv && !pr) begin
                chk("hold_valid", 64'(data_out_valid), 64'd1);
                chk("hold_data", {data_out, data_out_channel}, phead);
            end
            if (data_out_valid && data_out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %0h expected no output", {data_out, data_out_channel});
                end else begin
                    popped = sb.pop_front();
                    chk("pop_word", {data_out, data_out_channel}, popped);
                end
                log_q.push_back({data_out, data_out_channel});
            end
            pv = data_out_valid;
            pr = data_out_ready;
            phead = {data_out, data_out_channel};
        end
    end

    task automatic step(input logic g, input logic [2:0] c, input logic [7:0] d);
        data_good = g;
        channel = c;
        data = d;
        @(posedge clk);
        #1;
        data_good = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0);
    endtask

    task automatic reset();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(data_out_valid), 64'd0);
        chk("rst_out", {data_out, data_out_channel}, 64'd0);
        chk("rst_counts", {drop_count, timeout_count, overflow_count}, 64'd0);
        @(posedge clk);
        #1;
        rst = 0;
        log_q.delete();
    endtask

    initial begin
        reset();
        data_out_ready = 1;
        step(1, 2, 8'hF1); step(1, 2, 8'h23); step(1, 2, 8'h45); step(1, 2, 8'h67);
        @(negedge clk);
        chk("p1_valid", 64'(data_out_valid), 64'd1);
        chk("p1_word", {data_out, data_out_channel}, {32'hF1234567, 3'd2});
        chk("p1_counts", {drop_count, timeout_count, overflow_count}, 64'd0);
        @(posedge clk);
        #1;
        idle(3);

        reset();
        step(1, 0, 8'hF0); step(1, 5, 8'hFA); step(1, 0, 8'h11); step(1, 5, 8'hBB);
        step(1, 0, 8'h22); step(1, 5, 8'hCC); step(1, 0, 8'h33); step(1, 5, 8'hDD);
        idle(3);
        chk("p2_npop", 64'(log_q.size()), 64'd2);
        chk("p2_first", log_q[0], {32'hF0112233, 3'd0});
        chk("p2_second", log_q[1], {32'hFABBCCDD, 3'd5});

        reset();
        step(1, 1, 8'h3A);
        repeat (4) step(1, 1, 8'hF9);
        idle(3);
        chk("p3_drop", 64'(drop_count), 64'd1);
        chk("p3_npop", 64'(log_q.size()), 64'd1);
        chk("p3_word", log_q[0], {32'hF9F9F9F9, 3'd1});

        reset();
        step(1, 3, 8'hF0); step(1, 3, 8'h01);
        idle(4);
        step(1, 3, 8'hF2); step(1, 3, 8'h03); step(1, 3, 8'h04); step(1, 3, 8'h05);
        idle(3);
        chk("p4_timeout", 64'(timeout_count), 64'd1);
        chk("p4_npop", 64'(log_q.size()), 64'd1);
        chk("p4_word", log_q[0], {32'hF2030405, 3'd3});

        reset();
        data_out_ready = 0;
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 8'hF0 + 8'(i));
            repeat (3) step(1, 0, 8'(i));
        end
        idle(2);
        chk("p5_overflow", 64'(overflow_count), 64'd1);
        chk("p5_valid", 64'(data_out_valid), 64'd1);
        data_out_ready = 1;
        idle(12);
        chk("p5_npop", 64'(log_q.size()), 64'd8);
        for (int k = 0; k < 8; k++)
            chk("p5_order", log_q[k], {8'hF0 + 8'(k), 8'(k), 8'(k), 8'(k), 3'd0});

        reset();
        step(1, 4, 8'hF5); step(1, 4, 8'h66);
        reset();
        step(1, 4, 8'h04); step(1, 4, 8'hF1); step(1, 4, 8'h02); step(1, 4, 8'h03); step(1, 4, 8'h04);
        idle(3);
        chk("p6_drop", 64'(drop_count), 64'd1);
        chk("p6_npop", 64'(log_q.size()), 64'd1);
        chk("p6_word", log_q[0], {32'hF1020304, 3'd4});

        reset();
        repeat (3000) begin
            data_out_ready = $urandom_range(0, 3) != 0;
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0 ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1)),
                 $urandom_range(0, 1) != 0 ? {4'hF, 4'($urandom)} : 8'($urandom));
        end
        data_out_ready = 1;
        idle(40);
        chk("rnd_drained", 64'(sb.size()), 64'd0);
        chk("rnd_drop", 64'(drop_count), 64'(m_drop));
        chk("rnd_timeout", 64'(timeout_count), 64'(m_tmo));
        chk("rnd_overflow", 64'(overflow_count), 64'(m_ovf));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
